digit_entry_sequencer: RTL and testbench
========================================

# digit_entry_sequencer

Sequences entry of a multi-digit code into a bank of 4-bit load-register slots. Accepts one digit per input strobe and steers it into the next free slot with a one-hot load strobe. Presents the assembled code and a ready flag to the downstream comparator, then waits for acknowledge or clear before starting over. Sits between the button/keypad front end and the code-check logic.

## Interface
- NUM_DIGITS, 4, number of digit slots (≥2)
- DIGIT_W, 4, bits per digit
- TIMEOUT_CYCLES, 1000, idle cycles before a partial entry is aborted (used only with DIGIT_TIMEOUT_EN)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- digit_in  in  DIGIT_W  digit value, sampled when digit_valid=1
- digit_valid  in  1  single-cycle digit strobe
- clear  in  1  abort entry, empty all slots
- consume  in  1  downstream acknowledge of a full code
- load_en  out  NUM_DIGITS  one-hot slot load strobe (combinational)
- code_out  out  NUM_DIGITS*DIGIT_W  slot contents; slot 0 in bits [DIGIT_W-1:0]
- digit_count  out  clog2(NUM_DIGITS+1)  digits currently held
- code_ready  out  1  all slots filled
- timeout  out  1  one-cycle pulse on timeout abort (constant 0 without macro)

## Operation
- States:
  - IDLE: count=0.
  - ENTRY: 0<count<NUM_DIGITS.
  - FULL: count=NUM_DIGITS.
- Accept: digit_valid=1 in IDLE/ENTRY with clear=0.
  - load_en[count]=1 that cycle.
  - slot[count] captures digit_in at the edge; count increments at the same edge.
- Transitions:
  - IDLE→ENTRY on accept.
  - ENTRY→FULL on accept when count=NUM_DIGITS-1.
  - FULL→IDLE on consume.
  - any state→IDLE on clear.
- Priority: clear > consume > digit_valid.
  - clear with digit_valid drops the digit; load_en stays 0.
- FULL: digit_valid is ignored; load_en=0 and slots hold.
- Empty action (clear, consume in FULL, or timeout): all slots→0, count→0, code_ready→0 at that edge.
- consume outside FULL: ignored.
- clear in IDLE: no-op; slots are already 0.
- load_en is never multi-hot, and is never asserted in FULL or while clear=1.

## Timing
- Reset (rst=0, asynchronous): state IDLE, all slots 0, digit_count 0, code_ready 0, timeout 0, idle counter 0.
  - load_en is 0 during reset.
- Accept latency: code_out and digit_count reflect a digit the cycle after its strobe edge.
- code_ready is registered. It rises the cycle after the NUM_DIGITS-th accept edge and falls the cycle after the consume/clear edge.
- Back-to-back strobes on consecutive cycles are all accepted. One digit per cycle maximum.
- Reset mid-entry discards the partial code immediately.

## Configuration
- DIGIT_TIMEOUT_EN defined:
  - An idle counter runs in ENTRY only. It resets to 0 on every accept and on entering ENTRY.
  - After TIMEOUT_CYCLES consecutive cycles in ENTRY without an accept, the block performs an empty action, returns to IDLE, and pulses timeout high for exactly one cycle.
  - A clear or accept in the expiring cycle takes priority; no timeout pulse is issued.
- DIGIT_TIMEOUT_EN undefined:
  - No idle counter is built; timeout is tied to 0.
  - A partial entry persists indefinitely.

## Structure
- Shared package:
  - state encoding typedef (IDLE, ENTRY, FULL)
  - default DIGIT_W and NUM_DIGITS constants
  - count-width helper function
- Sub-module digit_slot: DIGIT_W register with asynchronous active-low reset, synchronous clr, and load. It is instantiated NUM_DIGITS times, driven by load_en[i] and the empty action.
- The FSM, counter and optional timeout counter live in digit_entry_sequencer.

## Test plan
- Reset then strobes 3,7,1,9 on consecutive cycles:
  - load_en 0001,0010,0100,1000
  - code_out=16'h9173 and code_ready=1 the cycle after the 4th strobe
- FULL plus extra strobe digit 5: load_en=0, code_out stays 16'h9173. Then consume: next cycle code_out=0, digit_count=0, code_ready=0.
- Two digits entered, then clear and digit_valid (digit 4) in the same cycle: digit dropped, digit_count=0, slots 0.
- rst pulsed low asynchronously after 3 digits: outputs 0 immediately, without waiting for a clk edge.
- consume pulsed in IDLE and in ENTRY with count=2: no effect, digit_count unchanged.
- DIGIT_TIMEOUT_EN, TIMEOUT_CYCLES=8:
  - 1 digit, then idle 8 cycles → timeout pulses once, count=0.
  - Repeat with a strobe at idle cycle 7 → no timeout, count=2.

Source files
------------

// File: rtl/digit_entry_sequencer_pkg.sv
// Shared types and constants for the digit entry sequencer.
package digit_entry_sequencer_pkg;

    localparam int unsigned DEF_NUM_DIGITS = 4;
    localparam int unsigned DEF_DIGIT_W    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Width needed to hold a count of 0..n
    function automatic int unsigned count_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/digit_slot.sv
// One digit register of the code bank: async reset, sync clear, load enable.
module digit_slot #(
    parameter int unsigned DIGIT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               load,
    input  logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/digit_entry_sequencer.sv
// Steers strobed digits into a bank of slots and presents the full code.
// Optional idle abort of partial entries is built when DIGIT_TIMEOUT_EN is defined.
module digit_entry_sequencer
    import digit_entry_sequencer_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = DEF_NUM_DIGITS,
    parameter int unsigned DIGIT_W        = DEF_DIGIT_W,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DIGIT_W-1:0]              digit_in,
    input  logic                            digit_valid,
    input  logic                            clear,
    input  logic                            consume,
    output logic [NUM_DIGITS-1:0]           load_en,
    output logic [NUM_DIGITS*DIGIT_W-1:0]   code_out,
    output logic [count_w(NUM_DIGITS)-1:0]  digit_count,
    output logic                            code_ready,
    output logic                            timeout
);

    localparam int unsigned CW = count_w(NUM_DIGITS);

    state_t        state;
    logic [CW-1:0] count;
    logic          accept;
    logic          empty;
    logic          timeout_fire;

    // Reset gating keeps load_en quiet while rst is held low
    assign accept = rst && digit_valid && !clear && (state != FULL);
    assign empty  = clear || ((state == FULL) && consume) || timeout_fire;

    always_comb begin
        load_en = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (accept && (count == CW'(i))) begin
                load_en[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            count      <= '0;
            code_ready <= 1'b0;
        end else if (empty) begin
            state      <= IDLE;
            count      <= '0;
            code_ready <= 1'b0;
        end else if (accept) begin
            count <= count + CW'(1);
            if (count == CW'(NUM_DIGITS - 1)) begin
                state      <= FULL;
                code_ready <= 1'b1;
            end else begin
                state <= ENTRY;
            end
        end
    end

    assign digit_count = count;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_slot
        digit_slot #(
            .DIGIT_W (DIGIT_W)
        ) u_slot (
            .clk  (clk),
            .rst  (rst),
            .clr  (empty),
            .load (load_en[g]),
            .d    (digit_in),
            .q    (code_out[g*DIGIT_W +: DIGIT_W])
        );
    end

`ifdef DIGIT_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idle_cnt;

    // A clear or accept in the expiring cycle wins over the abort
    assign timeout_fire = (state == ENTRY) && !clear && !accept &&
                          (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= timeout_fire;
            if ((state != ENTRY) || accept || empty) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + TW'(1);
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
    assign timeout_fire       = 1'b0;
    assign timeout            = 1'b0;
`endif

endmodule

// File: tb/tb_digit_entry_sequencer.sv
// Self-checking bench for digit_entry_sequencer (4 digits x 4 bits, timeout 8).
module tb_digit_entry_sequencer;

    logic        clk;
    logic        rst;
    logic [3:0]  digit_in;
    logic        digit_valid;
    logic        clear;
    logic        consume;
    logic [3:0]  load_en;
    logic [15:0] code_out;
    logic [2:0]  digit_count;
    logic        code_ready;
    logic        timeout;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        dv;
        logic [3:0]  d;
        logic        clr;
        logic        cons;
        logic [3:0]  load;
        logic [15:0] code;
        logic [2:0]  cnt;
        logic        rdy;
    } vec_t;

    typedef struct {
        logic [15:0] code;
        logic [2:0]  cnt;
        logic        rdy;
        logic        tmo;
        string       name;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[19];

    digit_entry_sequencer #(
        .NUM_DIGITS     (4),
        .DIGIT_W        (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .digit_in    (digit_in),
        .digit_valid (digit_valid),
        .clear       (clear),
        .consume     (consume),
        .load_en     (load_en),
        .code_out    (code_out),
        .digit_count (digit_count),
        .code_ready  (code_ready),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout-of-run want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Called 1 time unit after a rising edge: drive one cycle, check load_en, then post-edge state
    task automatic step(input logic dv, input logic [3:0] d, input logic clr_i, input logic cons,
                        input logic [3:0] exp_load, input logic [15:0] exp_code,
                        input logic [2:0] exp_cnt, input logic exp_rdy, input logic exp_tmo,
                        input string name);
        exp_t e;
        digit_valid = dv;
        digit_in    = d;
        clear       = clr_i;
        consume     = cons;
        #1;
        chk({name, ".load_en"}, 32'(load_en), 32'(exp_load));
        e.code = exp_code;
        e.cnt  = exp_cnt;
        e.rdy  = exp_rdy;
        e.tmo  = exp_tmo;
        e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        digit_valid = 1'b0;
        clear       = 1'b0;
        consume     = 1'b0;
        e = sb.pop_front();
        chk({e.name, ".code_out"},    32'(code_out),    32'(e.code));
        chk({e.name, ".digit_count"}, 32'(digit_count), 32'(e.cnt));
        chk({e.name, ".code_ready"},  32'(code_ready),  32'(e.rdy));
        chk({e.name, ".timeout"},     32'(timeout),     32'(e.tmo));
    endtask

    task automatic idle(input logic [15:0] exp_code, input logic [2:0] exp_cnt,
                        input logic exp_tmo, input string name);
        step(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, exp_code, exp_cnt, 1'b0, exp_tmo, name);
    endtask

    initial begin
        //          dv    d     clr   cons  load   code      cnt   rdy
        vecs[0]  = '{1'b1, 4'h3, 1'b0, 1'b0, 4'h1, 16'h0003, 3'd1, 1'b0};
        vecs[1]  = '{1'b1, 4'h7, 1'b0, 1'b0, 4'h2, 16'h0073, 3'd2, 1'b0};
        vecs[2]  = '{1'b1, 4'h1, 1'b0, 1'b0, 4'h4, 16'h0173, 3'd3, 1'b0};
        vecs[3]  = '{1'b1, 4'h9, 1'b0, 1'b0, 4'h8, 16'h9173, 3'd4, 1'b1};
        vecs[4]  = '{1'b1, 4'h5, 1'b0, 1'b0, 4'h0, 16'h9173, 3'd4, 1'b1};
        vecs[5]  = '{1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 16'h0000, 3'd0, 1'b0};
        vecs[6]  = '{1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 16'h0000, 3'd0, 1'b0};
        vecs[7]  = '{1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 16'h0000, 3'd0, 1'b0};
        vecs[8]  = '{1'b1, 4'h2, 1'b0, 1'b0, 4'h1, 16'h0002, 3'd1, 1'b0};
        vecs[9]  = '{1'b1, 4'h6, 1'b0, 1'b0, 4'h2, 16'h0062, 3'd2, 1'b0};
        vecs[10] = '{1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 16'h0062, 3'd2, 1'b0};
        vecs[11] = '{1'b1, 4'h4, 1'b1, 1'b0, 4'h0, 16'h0000, 3'd0, 1'b0};
        vecs[12] = '{1'b1, 4'hA, 1'b0, 1'b0, 4'h1, 16'h000A, 3'd1, 1'b0};
        vecs[13] = '{1'b1, 4'hB, 1'b0, 1'b1, 4'h2, 16'h00BA, 3'd2, 1'b0};
        vecs[14] = '{1'b1, 4'hC, 1'b0, 1'b0, 4'h4, 16'h0CBA, 3'd3, 1'b0};
        vecs[15] = '{1'b1, 4'hD, 1'b0, 1'b0, 4'h8, 16'hDCBA, 3'd4, 1'b1};
        vecs[16] = '{1'b1, 4'h1, 1'b0, 1'b1, 4'h0, 16'h0000, 3'd0, 1'b0};
        vecs[17] = '{1'b1, 4'hF, 1'b0, 1'b0, 4'h1, 16'h000F, 3'd1, 1'b0};
        vecs[18] = '{1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 16'h0000, 3'd0, 1'b0};

        // Reset with a strobe present: nothing may load
        rst         = 1'b0;
        digit_in    = 4'h3;
        digit_valid = 1'b1;
        clear       = 1'b0;
        consume     = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset.load_en",     32'(load_en),     32'h0);
        chk("reset.code_out",    32'(code_out),    32'h0);
        chk("reset.digit_count", 32'(digit_count), 32'h0);
        chk("reset.code_ready",  32'(code_ready),  32'h0);
        chk("reset.timeout",     32'(timeout),     32'h0);
        digit_valid = 1'b0;
        rst         = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 19; i++) begin
            step(vecs[i].dv, vecs[i].d, vecs[i].clr, vecs[i].cons, vecs[i].load,
                 vecs[i].code, vecs[i].cnt, vecs[i].rdy, 1'b0, $sformatf("vec%0d", i));
        end

        // Asynchronous reset mid-entry
        step(1'b1, 4'h3, 1'b0, 1'b0, 4'h1, 16'h0003, 3'd1, 1'b0, 1'b0, "ar0");
        step(1'b1, 4'h7, 1'b0, 1'b0, 4'h2, 16'h0073, 3'd2, 1'b0, 1'b0, "ar1");
        step(1'b1, 4'h1, 1'b0, 1'b0, 4'h4, 16'h0173, 3'd3, 1'b0, 1'b0, "ar2");
        #2;
        digit_valid = 1'b1;
        digit_in    = 4'h8;
        rst         = 1'b0;
        #1;
        chk("async_rst.code_out",    32'(code_out),    32'h0);
        chk("async_rst.digit_count", 32'(digit_count), 32'h0);
        chk("async_rst.code_ready",  32'(code_ready),  32'h0);
        chk("async_rst.load_en",     32'(load_en),     32'h0);
        digit_valid = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("after_rst.digit_count", 32'(digit_count), 32'h0);

`ifdef DIGIT_TIMEOUT_EN
        // Eight idle cycles in ENTRY abort the partial code with a one-cycle pulse
        step(1'b1, 4'h4, 1'b0, 1'b0, 4'h1, 16'h0004, 3'd1, 1'b0, 1'b0, "to_a.d0");
        for (int k = 1; k <= 7; k++) idle(16'h0004, 3'd1, 1'b0, $sformatf("to_a.idle%0d", k));
        idle(16'h0000, 3'd0, 1'b1, "to_a.idle8");
        idle(16'h0000, 3'd0, 1'b0, "to_a.after");

        // Strobe at idle cycle 7 restarts the count
        step(1'b1, 4'h4, 1'b0, 1'b0, 4'h1, 16'h0004, 3'd1, 1'b0, 1'b0, "to_b.d0");
        for (int k = 1; k <= 6; k++) idle(16'h0004, 3'd1, 1'b0, $sformatf("to_b.idle%0d", k));
        step(1'b1, 4'h5, 1'b0, 1'b0, 4'h2, 16'h0054, 3'd2, 1'b0, 1'b0, "to_b.d1");
        idle(16'h0054, 3'd2, 1'b0, "to_b.after");
        step(1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 16'h0000, 3'd0, 1'b0, 1'b0, "to_b.clr");

        // Accept in the expiring cycle wins
        step(1'b1, 4'h4, 1'b0, 1'b0, 4'h1, 16'h0004, 3'd1, 1'b0, 1'b0, "to_c.d0");
        for (int k = 1; k <= 7; k++) idle(16'h0004, 3'd1, 1'b0, $sformatf("to_c.idle%0d", k));
        step(1'b1, 4'h5, 1'b0, 1'b0, 4'h2, 16'h0054, 3'd2, 1'b0, 1'b0, "to_c.d1");
        idle(16'h0054, 3'd2, 1'b0, "to_c.after");
        step(1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 16'h0000, 3'd0, 1'b0, 1'b0, "to_c.clr");

        // Clear in the expiring cycle wins, no pulse
        step(1'b1, 4'h6, 1'b0, 1'b0, 4'h1, 16'h0006, 3'd1, 1'b0, 1'b0, "to_d.d0");
        for (int k = 1; k <= 7; k++) idle(16'h0006, 3'd1, 1'b0, $sformatf("to_d.idle%0d", k));
        step(1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 16'h0000, 3'd0, 1'b0, 1'b0, "to_d.clr");
        idle(16'h0000, 3'd0, 1'b0, "to_d.after");
`else
        // Without the timeout feature a partial entry persists
        step(1'b1, 4'h4, 1'b0, 1'b0, 4'h1, 16'h0004, 3'd1, 1'b0, 1'b0, "persist.d0");
        for (int k = 1; k <= 20; k++) idle(16'h0004, 3'd1, 1'b0, $sformatf("persist.idle%0d", k));
        step(1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 16'h0000, 3'd0, 1'b0, 1'b0, "persist.clr");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
